fifo_wptr_full: RTL and testbench

// - Write-side pointer and full-flag controller for the async FIFO; sits directly upstream of fifo_mem in the wclk domain.
// - Maintains binary/Gray write pointers and synchronises the read-domain Gray pointer (2-FF).
// - Produces full, almost_full, fill level and a sticky overflow flag.
// - b_wptr and full drive fifo_mem; g_wptr goes to the read-domain synchroniser.

---
 rtl/fifo_wptr_full.sv | 102 ++++++++++
 tb/tb_fifo_wptr_full.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/full controller for the async FIFO (wclk domain).
// Keeps binary/Gray write pointers, syncs the read Gray pointer and derives the fill flags.
module fifo_wptr_full #(
    parameter int unsigned PTR_WIDTH = 6,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AF_THRESH = 56
) (
    input  logic               wclk_i,
    input  logic               wrst_i,
    input  logic               w_en_i,
    input  logic [PTR_WIDTH:0] g_rptr_i,
    output logic [PTR_WIDTH:0] b_wptr_o,
    output logic [PTR_WIDTH:0] g_wptr_o,
    output logic               full_o,
    output logic               almost_full_o,
    output logic [PTR_WIDTH:0] wr_level_o,
    output logic               wr_accept_o,
    output logic               overflow_o
);

    if (PTR_WIDTH < 2) begin : g_bad_width
        $error("fifo_wptr_full: PTR_WIDTH must be >= 2");
    end
    if (DEPTH != (1 << PTR_WIDTH)) begin : g_bad_depth
        $error("fifo_wptr_full: DEPTH must equal 2**PTR_WIDTH");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wptr_full: AF_THRESH must be in 1..DEPTH");
    end

    localparam logic [PTR_WIDTH:0] DepthW   = DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AfThresh = AF_THRESH[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] rq1_q, rq2_q;
    logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
    logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic               full_q, full_d;
    logic               af_q, af_d;
    logic               ovf_q, ovf_d;
    logic [PTR_WIDTH:0] rbin;
    logic               wr_accept;

    assign wr_accept = w_en_i & ~full_q;

    always_comb begin
        rbin            = '0;
        rbin[PTR_WIDTH] = rq2_q[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rq2_q[i];
        end
    end

    always_comb begin
        b_wptr_d = b_wptr_q + {{PTR_WIDTH{1'b0}}, wr_accept};
        g_wptr_d = b_wptr_d ^ (b_wptr_d >> 1);
        level_d  = b_wptr_d - rbin;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        full_d   = (g_wptr_d == {~rq2_q[PTR_WIDTH:PTR_WIDTH-1], rq2_q[PTR_WIDTH-2:0]});
        af_d     = (level_d >= AfThresh);
        ovf_d    = ovf_q | (w_en_i & full_q);
    end

    always_ff @(posedge wclk_i) begin
        if (wrst_i) begin
            rq1_q    <= '0;
            rq2_q    <= '0;
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rq1_q    <= g_rptr_i;
            rq2_q    <= rq1_q;
            b_wptr_q <= b_wptr_d;
            g_wptr_q <= g_wptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    // Registered state is checked at each edge where it was not just reset.
    always_ff @(posedge wclk_i) begin
        if (!wrst_i) begin
            assert (full_q == (level_q == DepthW))
            else $error("fifo_wptr_full: full disagrees with wr_level");
        end
    end

    assign b_wptr_o      = b_wptr_q;
    assign g_wptr_o      = g_wptr_q;
    assign full_o        = full_q;
    assign almost_full_o = af_q;
    assign wr_level_o    = level_q;
    assign wr_accept_o   = wr_accept;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboarded bench for fifo_wptr_full: a count-based reader/writer model predicts every cycle,
// directed checks cover reset, fill, release, almost-full, wrap and mid-operation reset.
module tb_fifo_wptr_full;

    localparam int Depth = 64;
    localparam int AfTh  = 56;
    localparam int Mod   = 128;
    localparam int Budget = 5000;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       w_en;
    logic [6:0] g_rptr;
    logic [6:0] b_wptr, g_wptr, wr_level;
    logic       full, almost_full, wr_accept, overflow;

    fifo_wptr_full #(.PTR_WIDTH(6), .DEPTH(64), .AF_THRESH(56)) dut (
        .wclk_i       (wclk),
        .wrst_i       (wrst),
        .w_en_i       (w_en),
        .g_rptr_i     (g_rptr),
        .b_wptr_o     (b_wptr),
        .g_wptr_o     (g_wptr),
        .full_o       (full),
        .almost_full_o(almost_full),
        .wr_level_o   (wr_level),
        .wr_accept_o  (wr_accept),
        .overflow_o   (overflow)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] b;
        logic [6:0] g;
        logic [6:0] lvl;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] bin2gray(input int v);
        logic [6:0] b;
        b = v[6:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int gray2bin(input logic [6:0] g);
        int r;
        r = 0;
        for (int i = 6; i >= 0; i--) r[i] = ^(g >> i);
        return r;
    endfunction

    // Reference model: counts of writes and of synced reads, two-edge sync delay.
    int m_wabs = 0;
    int m_wcnt = 0;
    int m_r1 = 0, m_r2 = 0, m_lvl = 0;
    bit m_full = 0, m_af = 0, m_ovf = 0;

    initial forever begin
        exp_t e;
        bit   acc;
        @(posedge wclk);
        if (wrst) begin
            m_wabs = 0; m_wcnt = 0; m_r1 = 0; m_r2 = 0; m_lvl = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            acc    = w_en && !m_full;
            m_ovf  = m_ovf || (w_en && m_full);
            m_wabs = m_wabs + int'(acc);
            m_wcnt = (m_wcnt + int'(acc)) % Mod;
            m_lvl  = ((m_wcnt - m_r2) % Mod + Mod) % Mod;
            m_full = (m_lvl == Depth);
            m_af   = (m_lvl >= AfTh);
            m_r2   = m_r1;
            m_r1   = gray2bin(g_rptr);
        end
        e.b    = m_wcnt[6:0];
        e.g    = bin2gray(m_wcnt);
        e.lvl  = m_lvl[6:0];
        e.full = m_full;
        e.af   = m_af;
        e.ovf  = m_ovf;
        sb_q.push_back(e);
    end

    // Monitor: pops one expectation per registered update.
    initial forever begin
        exp_t e;
        @(negedge wclk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp("sb_b_wptr", b_wptr, e.b);
            cmp("sb_g_wptr", g_wptr, e.g);
            cmp("sb_wr_level", wr_level, e.lvl);
            cmp("sb_full", {6'd0, full}, {6'd0, e.full});
            cmp("sb_almost_full", {6'd0, almost_full}, {6'd0, e.af});
            cmp("sb_overflow", {6'd0, overflow}, {6'd0, e.ovf});
            cmp("sb_wr_accept", {6'd0, wr_accept}, {6'd0, w_en & ~e.full});
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    int         rabs;
    int         cyc;
    int         occ;
    bit         wrap_seen;
    logic [6:0] pb, pg;

    initial begin
        // Reset with activity on the inputs
        wrst = 1'b1; w_en = 1'b1; g_rptr = 7'h15; rabs = 0;
        step();
        cmp("rst_b_wptr", b_wptr, 7'd0);
        cmp("rst_g_wptr", g_wptr, 7'd0);
        cmp("rst_wr_level", wr_level, 7'd0);
        cmp("rst_flags", {3'd0, full, almost_full, overflow, 1'b0}, 7'd0);
        step();
        wrst = 1'b0; g_rptr = 7'd0;
        #1;
        cmp("rel_wr_accept", {6'd0, wr_accept}, 7'd1);
        w_en = 1'b0;
        repeat (2) step();

        // Fill to full, then one write too many
        w_en = 1'b1;
        repeat (64) step();
        cmp("fill_full", {6'd0, full}, 7'd1);
        cmp("fill_b_wptr", b_wptr, 7'd64);
        cmp("fill_g_wptr", g_wptr, 7'b1100000);
        cmp("fill_level", wr_level, 7'd64);
        cmp("fill_accept", {6'd0, wr_accept}, 7'd0);
        step();
        cmp("ovf_b_wptr", b_wptr, 7'd64);
        cmp("ovf_set", {6'd0, overflow}, 7'd1);
        cmp("ovf_full", {6'd0, full}, 7'd1);

        // Release by one read: visible on the third edge
        w_en = 1'b0; g_rptr = 7'b0000001;
        step();
        cmp("rel1_level", wr_level, 7'd64);
        step();
        cmp("rel2_full", {6'd0, full}, 7'd1);
        step();
        cmp("rel3_full", {6'd0, full}, 7'd0);
        cmp("rel3_level", wr_level, 7'd63);

        // Almost-full threshold
        wrst = 1'b1; g_rptr = 7'd0;
        step();
        wrst = 1'b0; w_en = 1'b1;
        repeat (55) step();
        cmp("af55", {6'd0, almost_full}, 7'd0);
        step();
        cmp("af56", {6'd0, almost_full}, 7'd1);
        cmp("af56_full", {6'd0, full}, 7'd0);
        w_en = 1'b0;

        // Wrap with a modelled reader keeping occupancy around 10..20
        wrst = 1'b1; rabs = 0; g_rptr = 7'd0;
        step();
        wrst = 1'b0;
        wrap_seen = 0; cyc = 0; pb = 7'd0; pg = 7'd0;
        while (m_wabs < 315 && cyc < Budget) begin
            occ  = m_wabs - rabs;
            w_en = (occ < 20) ? ($urandom_range(3) != 0) : 1'b0;
            if (occ > 10 && $urandom_range(1) == 1) begin
                rabs++;
                g_rptr = bin2gray(rabs % Mod);
            end
            step();
            if (pb == 7'd127 && pg == 7'b1000000 && b_wptr == 7'd0 && g_wptr == 7'd0)
                wrap_seen = 1;
            pb = b_wptr; pg = g_wptr;
            cyc++;
        end
        cmp("wrap_in_budget", {6'd0, cyc < Budget}, 7'd1);
        cmp("wrap_seen", {6'd0, wrap_seen}, 7'd1);
        w_en = 1'b0;

        // Mid-operation reset with overflow set and level 40
        wrst = 1'b1; rabs = 0; g_rptr = 7'd0;
        step();
        wrst = 1'b0; w_en = 1'b1;
        repeat (65) step();
        cmp("mid_ovf", {6'd0, overflow}, 7'd1);
        w_en = 1'b0; g_rptr = bin2gray(24);
        repeat (3) step();
        cmp("mid_level40", wr_level, 7'd40);
        w_en = 1'b1; wrst = 1'b1;
        step();
        cmp("mid_b_wptr", b_wptr, 7'd0);
        cmp("mid_level", wr_level, 7'd0);
        cmp("mid_ovf_clr", {6'd0, overflow}, 7'd0);
        cmp("mid_full", {6'd0, full}, 7'd0);
        wrst = 1'b0; w_en = 1'b0; g_rptr = 7'd0;
        repeat (3) step();

        @(negedge wclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
